mem_wait_bridge: RTL and testbench

Parametrised memory glue between the single-cycle `cpu` core and the instruction/data memories. It replaces the fixed address-subtract wiring with configurable base addresses and window sizes, and programmable wait states with a CPU stall handshake. It also adds single-pulse write strobes and sticky out-of-window fault capture. It sits inside the top-level dataflow, between `cpu` and `my_imem`/`my_dmem`.

---
 rtl/mem_wait_bridge_if.sv | 35 +++
 rtl/mem_wait_bridge.sv | 130 +++++++++++++
 tb/tb_mem_wait_bridge.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wait_bridge_if.sv
// CPU <-> memory bus bundle for mem_wait_bridge.
// slave = the bridge's view, master = the CPU/memory side driving requests.
interface mem_wait_bridge_if #(
    parameter int IM_AW = 11,
    parameter int DM_AW = 6
);
    logic [31:0]       pc_in;
    logic              dm_req;
    logic              dm_we;
    logic [1:0]        dm_opt_in;
    logic [31:0]       dm_addr_in;
    logic [31:0]       dm_wdata_in;
    logic [IM_AW-1:0]  im_addr;
    logic [DM_AW-1:0]  dm_addr;
    logic              dm_e;
    logic              dm_r;
    logic              dm_w;
    logic [1:0]        dm_opt;
    logic [31:0]       dm_wdata;
    logic              stall;
    logic              fault;
    logic [31:0]       fault_addr;

    modport slave (
        input  pc_in, dm_req, dm_we, dm_opt_in, dm_addr_in, dm_wdata_in,
        output im_addr, dm_addr, dm_e, dm_r, dm_w, dm_opt, dm_wdata,
               stall, fault, fault_addr
    );

    modport master (
        output pc_in, dm_req, dm_we, dm_opt_in, dm_addr_in, dm_wdata_in,
        input  im_addr, dm_addr, dm_e, dm_r, dm_w, dm_opt, dm_wdata,
               stall, fault, fault_addr
    );
endinterface

// File: rtl/mem_wait_bridge.sv
// Memory glue between cpu and imem/dmem: windowed address translation, wait-state stall FSM,
// single-pulse writes and sticky fault capture. MEM_BRIDGE_ALIGN_CHECK_EN adds data alignment faults.
//
// state     | meaning
// S_IDLE    | new access; zero-wait passes straight through, otherwise load cnt and stall
// S_WAIT    | counting down wait states, stall held
// S_RELEASE | final cycle of a waited access, CPU advances at the closing edge
module mem_wait_bridge #(
    parameter logic [31:0] PC_START = 32'h0040_0000,
    parameter logic [31:0] DM_START = 32'h1001_0000,
    parameter int          IM_AW    = 11,
    parameter int          DM_AW    = 6,
    parameter int          IM_WAIT  = 0,
    parameter int          DM_WAIT  = 0
) (
    input  logic               clk_in,
    input  logic               reset,
    mem_wait_bridge_if.slave   bus
);

    if (IM_WAIT < 0 || IM_WAIT > 15 || DM_WAIT < 0 || DM_WAIT > 15) begin : g_wait_range
        $error("mem_wait_bridge: IM_WAIT and DM_WAIT must be within 0..15");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam logic [3:0]  IM_W4   = 4'(IM_WAIT);
    localparam logic [3:0]  DM_W4   = 4'(DM_WAIT);
    localparam logic [32:0] IM_SPAN = 33'd4 << IM_AW;
    localparam logic [32:0] DM_SPAN = 33'd1 << DM_AW;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         fault_q, fault_d;
    logic [31:0]  fault_addr_q, fault_addr_d;

    logic [31:0]  im_off, dm_off;
    logic         im_bad, dm_oow, dm_misalign, dm_bad;
    logic [3:0]   w_eff;
    logic         stall_c, final_c, rd_ok;

    // Unsigned subtraction folds "below base" into the same compare as "past the top".
    assign im_off = bus.pc_in - PC_START;
    assign dm_off = bus.dm_addr_in - DM_START;
    assign im_bad = {1'b0, im_off} >= IM_SPAN;
    assign dm_oow = {1'b0, dm_off} >= DM_SPAN;

`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
    always_comb begin
        dm_misalign = 1'b0;
        case (bus.dm_opt_in)
            2'b01:   dm_misalign = bus.dm_addr_in[0];
            2'b10:   dm_misalign = 1'b0;
            default: dm_misalign = |bus.dm_addr_in[1:0];
        endcase
    end
`else
    assign dm_misalign = 1'b0;
`endif

    assign dm_bad = bus.dm_req & (dm_oow | dm_misalign);
    assign w_eff  = (bus.dm_req && (DM_W4 > IM_W4)) ? DM_W4 : IM_W4;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_c      = 1'b0;
        final_c      = 1'b0;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        case (state_q)
            S_IDLE: begin
                if (w_eff == 4'd0) begin
                    final_c = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = w_eff - 4'd1;
                    state_d = (w_eff > 4'd1) ? S_WAIT : S_RELEASE;
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                final_c = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // First fault wins; a data fault takes precedence over a fetch fault in the same cycle.
        if (!fault_q && (dm_bad || im_bad)) begin
            fault_d      = 1'b1;
            fault_addr_d = dm_bad ? bus.dm_addr_in : bus.pc_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Strobes stay combinational so a zero-wait build behaves exactly like plain glue.
    assign rd_ok          = ~reset & bus.dm_req & ~bus.dm_we & ~dm_bad;
    assign bus.im_addr    = im_off[IM_AW+1:2];
    assign bus.dm_addr    = dm_off[DM_AW-1:0];
    assign bus.dm_e       = rd_ok;
    assign bus.dm_r       = rd_ok;
    assign bus.dm_w       = ~reset & final_c & bus.dm_req & bus.dm_we & ~dm_bad;
    assign bus.dm_opt     = bus.dm_opt_in;
    assign bus.dm_wdata   = bus.dm_wdata_in;
    assign bus.stall      = ~reset & stall_c;
    assign bus.fault      = fault_q;
    assign bus.fault_addr = fault_addr_q;

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Directed bench for mem_wait_bridge: four instances with DM_WAIT = 0, 2, 3, 5 share one stimulus.
module tb_mem_wait_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_x = 1'b0;
    logic [31:0] pc = 32'h0040_0000;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  opt = 2'b00;
    logic [31:0] addr = 32'h1001_0000;
    logic [31:0] wdata = 32'h0;

    logic [3:0]        stall_v, dme_v, dmr_v, dmw_v, fault_v;
    logic [3:0][31:0]  fa_v, wd_v;
    logic [3:0][1:0]   opt_v;
    logic [3:0][10:0]  im_v;
    logic [3:0][5:0]   dm_v;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int DMW = (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 3 : 5;
        logic dut_rst;
        mem_wait_bridge_if ifc ();
        assign dut_rst         = rst | ((g == 3) && rst_x);
        assign ifc.pc_in       = pc;
        assign ifc.dm_req      = req;
        assign ifc.dm_we       = we;
        assign ifc.dm_opt_in   = opt;
        assign ifc.dm_addr_in  = addr;
        assign ifc.dm_wdata_in = wdata;
        assign stall_v[g] = ifc.stall;
        assign dme_v[g]   = ifc.dm_e;
        assign dmr_v[g]   = ifc.dm_r;
        assign dmw_v[g]   = ifc.dm_w;
        assign fault_v[g] = ifc.fault;
        assign fa_v[g]    = ifc.fault_addr;
        assign wd_v[g]    = ifc.dm_wdata;
        assign opt_v[g]   = ifc.dm_opt;
        assign im_v[g]    = ifc.im_addr;
        assign dm_v[g]    = ifc.dm_addr;
        mem_wait_bridge #(.DM_WAIT(DMW)) u_dut (
            .clk_in (clk),
            .reset  (dut_rst),
            .bus    (ifc.slave)
        );
    end

    typedef struct {
        logic [31:0] pc;
        logic        req;
        logic        we;
        logic [1:0]  opt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [10:0] im;
        logic [5:0]  dm;
        logic        e;
        logic        r;
        logic        w;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Holds a request for act_n cycles, observes tot cycles of instance d, returns per-cycle bitmasks.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d_in,
                          input int act_n, input int tot, input int d,
                          output logic [7:0] st_m, output logic [7:0] r_m,
                          output logic [7:0] w_m, output logic [31:0] wd_at_w);
        st_m = '0; r_m = '0; w_m = '0; wd_at_w = '0;
        we = w; addr = a; wdata = d_in; opt = 2'b00; req = 1'b1;
        for (int c = 0; c < tot; c++) begin
            @(negedge clk);
            st_m[c] = stall_v[d];
            r_m[c]  = dmr_v[d];
            w_m[c]  = dmw_v[d];
            if (dmw_v[d]) wd_at_w = wd_v[d];
            next_cycle();
            if (c == act_n - 1) req = 1'b0;
        end
    endtask

    initial begin
        logic [7:0]  st_m, r_m, w_m;
        logic [31:0] wd_at;

        tbl[0] = '{32'h0040_0010, 1'b1, 1'b0, 2'b00, 32'h1001_0008, 32'h0,         11'd4,    6'd8,  1'b1, 1'b1, 1'b0};
        tbl[1] = '{32'h0040_0000, 1'b1, 1'b1, 2'b00, 32'h1001_0000, 32'h1234_5678, 11'd0,    6'd0,  1'b0, 1'b0, 1'b1};
        tbl[2] = '{32'h0040_1FFC, 1'b1, 1'b0, 2'b10, 32'h1001_003F, 32'h0,         11'h7FF,  6'd63, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{32'h0040_0004, 1'b0, 1'b0, 2'b00, 32'h1001_0020, 32'h0,         11'd1,    6'd32, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{32'h0040_0100, 1'b1, 1'b1, 2'b01, 32'h1001_0012, 32'hA5A5_0F0F, 11'h040,  6'h12, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{32'h0040_0008, 1'b1, 1'b0, 2'b11, 32'h1001_003C, 32'h0,         11'd2,    6'h3C, 1'b1, 1'b1, 1'b0};

        // Reset cycle: strobes and stall suppressed even with a live request.
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h1001_0008;
        @(negedge clk);
        chk("reset_dm_e", 32'(dme_v[0]), 32'd0);
        chk("reset_dm_r", 32'(dmr_v[0]), 32'd0);
        chk("reset_stall_w5", 32'(stall_v[3]), 32'd0);
        do_reset();
        @(negedge clk);
        chk("reset_fault", 32'(fault_v[0]), 32'd0);
        chk("reset_fault_addr", fa_v[0], 32'd0);
        chk("reset_stall", 32'(stall_v[0]), 32'd0);

        // Zero-wait passthrough vectors on instance 0.
        next_cycle();
        for (int i = 0; i < 6; i++) begin
            pc = tbl[i].pc; req = tbl[i].req; we = tbl[i].we;
            opt = tbl[i].opt; addr = tbl[i].addr; wdata = tbl[i].wdata;
            @(negedge clk);
            chk($sformatf("v%0d_im_addr", i), 32'(im_v[0]), 32'(tbl[i].im));
            chk($sformatf("v%0d_dm_addr", i), 32'(dm_v[0]), 32'(tbl[i].dm));
            chk($sformatf("v%0d_dm_e", i), 32'(dme_v[0]), 32'(tbl[i].e));
            chk($sformatf("v%0d_dm_r", i), 32'(dmr_v[0]), 32'(tbl[i].r));
            chk($sformatf("v%0d_dm_w", i), 32'(dmw_v[0]), 32'(tbl[i].w));
            chk($sformatf("v%0d_dm_opt", i), 32'(opt_v[0]), 32'(tbl[i].opt));
            chk($sformatf("v%0d_dm_wdata", i), wd_v[0], tbl[i].wdata);
            chk($sformatf("v%0d_stall", i), 32'(stall_v[0]), 32'd0);
            chk($sformatf("v%0d_fault", i), 32'(fault_v[0]), 32'd0);
            next_cycle();
        end
        req = 1'b0;

        // DM_WAIT=3 load: 3 stall cycles, read held 4.
        do_reset();
        pc = 32'h0040_0000;
        access(1'b0, 32'h1001_0004, 32'h0, 4, 6, 2, st_m, r_m, w_m, wd_at);
        chk("w3_stall_mask", 32'(st_m), 32'h07);
        chk("w3_read_mask", 32'(r_m), 32'h0F);
        chk("w3_write_mask", 32'(w_m), 32'h00);

        // DM_WAIT=2 store: a single write pulse in the third cycle.
        do_reset();
        access(1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 3, 6, 1, st_m, r_m, w_m, wd_at);
        chk("w2_stall_mask", 32'(st_m), 32'h03);
        chk("w2_write_mask", 32'(w_m), 32'h04);
        chk("w2_wdata", wd_at, 32'hDEAD_BEEF);
        chk("w2_read_mask", 32'(r_m), 32'h00);

        // DM_WAIT=5 store with reset in the second stall cycle.
        do_reset();
        w_m = '0;
        we = 1'b1; addr = 32'h1001_0010; wdata = 32'hCAFE_F00D; opt = 2'b00; req = 1'b1;
        @(negedge clk);
        chk("w5_first_stall", 32'(stall_v[3]), 32'd1);
        w_m[0] = dmw_v[3];
        next_cycle();
        rst_x = 1'b1;
        @(negedge clk);
        w_m[1] = dmw_v[3];
        next_cycle();
        rst_x = 1'b0; req = 1'b0;
        @(negedge clk);
        chk("w5_stall_after_reset", 32'(stall_v[3]), 32'd0);
        for (int c = 2; c < 6; c++) begin
            @(negedge clk);
            w_m[c] = dmw_v[3];
        end
        chk("w5_no_write", 32'(w_m), 32'h00);
        chk("w5_idle_stall", 32'(stall_v[3]), 32'd0);

        // Out-of-window load, then a bad fetch that must not overwrite the capture.
        do_reset();
        pc = 32'h0040_0000; we = 1'b0; addr = 32'h1001_0040; req = 1'b1;
        @(negedge clk);
        chk("oow_dm_e", 32'(dme_v[0]), 32'd0);
        chk("oow_dm_r", 32'(dmr_v[0]), 32'd0);
        next_cycle();
        req = 1'b0; pc = 32'h0000_0000;
        @(negedge clk);
        chk("oow_fault", 32'(fault_v[0]), 32'd1);
        chk("oow_fault_addr", fa_v[0], 32'h1001_0040);
        next_cycle();
        @(negedge clk);
        chk("oow_fault_addr_sticky", fa_v[0], 32'h1001_0040);

        // Bad fetch alone: flagged, but the data side still works.
        do_reset();
        pc = 32'h0040_2000; we = 1'b0; addr = 32'h1001_0004; req = 1'b1;
        @(negedge clk);
        chk("if_fault_dm_r", 32'(dmr_v[0]), 32'd1);
        chk("if_fault_im_addr", 32'(im_v[0]), 32'd0);
        next_cycle();
        req = 1'b0; pc = 32'h0040_0000;
        @(negedge clk);
        chk("if_fault", 32'(fault_v[0]), 32'd1);
        chk("if_fault_addr", fa_v[0], 32'h0040_2000);

        // Simultaneous fetch and data faults: data address captured.
        do_reset();
        pc = 32'h003F_FFFC; addr = 32'h1001_0100; req = 1'b1;
        next_cycle();
        req = 1'b0; pc = 32'h0040_0000;
        @(negedge clk);
        chk("both_fault_addr", fa_v[0], 32'h1001_0100);

        // Misaligned word load.
        do_reset();
        pc = 32'h0040_0000; we = 1'b0; opt = 2'b00; addr = 32'h1001_0002; req = 1'b1;
        @(negedge clk);
`ifdef MEM_BRIDGE_ALIGN_CHECK_EN
        chk("align_dm_r", 32'(dmr_v[0]), 32'd0);
        next_cycle();
        req = 1'b0;
        @(negedge clk);
        chk("align_fault", 32'(fault_v[0]), 32'd1);
        chk("align_fault_addr", fa_v[0], 32'h1001_0002);
`else
        chk("align_dm_r", 32'(dmr_v[0]), 32'd1);
        chk("align_dm_addr", 32'(dm_v[0]), 32'd2);
        next_cycle();
        req = 1'b0;
        @(negedge clk);
        chk("align_fault", 32'(fault_v[0]), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
